// File: rtl/dpll_ctrl_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpll_ctrl_div_pkg
//  Description : Shared defaults, width helpers and correction encoding for the
//                bit-sync DPLL controllable divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package dpll_ctrl_div_pkg;

   // Default loop configuration shared with phase detector / demod timing
   localparam int DEF_DIV_N    = 32;
   localparam int DEF_FILT_K   = 8;
   localparam int DEF_LOCK_SYM = 64;

   // Correction applied at a symbol boundary
   typedef enum logic [1:0] {
      CORR_NONE = 2'd0,
      CORR_RET  = 2'd1,
      CORR_ADV  = 2'd2
   } corr_e;

   // Signed filter width able to hold +/-k
   function automatic int rw_width(input int k);
      return $clog2(k + 1) + 1;
   endfunction

   // Phase counter width for a period of n ticks
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dpll_ctrl_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : dpll_ctrl_div_if
//  Description : Phase-detector pulses in, recovered sync clocks / strobe /
//                lock status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dpll_ctrl_div_if;

   logic pd_bef;
   logic pd_aft;
   logic clk_i;
   logic clk_q;
   logic clk_sym;
   logic locked;

   // Phase-detector / consumer side
   modport master (
      output pd_bef, pd_aft,
      input  clk_i, clk_q, clk_sym, locked
   );

   // Divider side
   modport slave (
      input  pd_bef, pd_aft,
      output clk_i, clk_q, clk_sym, locked
   );

endinterface
`default_nettype wire

// File: rtl/dpll_ctrl_div_rw_filter.sv
`default_nettype none
// ============================================================================
//  Module      : dpll_rw_filter
//  Description : Random-walk loop filter. Integrates lead/lag pulses and emits
//                a one-cycle retard/advance request when |rw| reaches FILT_K.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpll_rw_filter
   import dpll_ctrl_div_pkg::*;
#(
   parameter int FILT_K = DEF_FILT_K
) (
   input  wire logic clk32,
   input  wire logic rst,
   input  wire logic pd_bef_i,
   input  wire logic pd_aft_i,
   output logic      ret_req_o,
   output logic      adv_req_o
);

   localparam int RW_W = rw_width(FILT_K);
   localparam logic signed [RW_W-1:0] C_POS_EDGE = RW_W'(FILT_K - 1);
   localparam logic signed [RW_W-1:0] C_NEG_EDGE = RW_W'(-(FILT_K - 1));
   localparam logic signed [RW_W-1:0] C_ONE      = RW_W'(1);

   logic signed [RW_W-1:0] rw_q, rw_d;
   logic                   ret_q, ret_d;
   logic                   adv_q, adv_d;

   // Next filter value; a step onto +/-FILT_K resets to 0 and raises a request
   always_comb begin
      rw_d  = rw_q;
      ret_d = 1'b0;
      adv_d = 1'b0;
      if (pd_bef_i && !pd_aft_i) begin
         if (rw_q == C_POS_EDGE) begin
            rw_d  = '0;
            ret_d = 1'b1;
         end else begin
            rw_d  = rw_q + C_ONE;
         end
      end else if (pd_aft_i && !pd_bef_i) begin
         if (rw_q == C_NEG_EDGE) begin
            rw_d  = '0;
            adv_d = 1'b1;
         end else begin
            rw_d  = rw_q - C_ONE;
         end
      end
   end

   // Filter state and registered request pulses
   always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
         rw_q  <= '0;
         ret_q <= 1'b0;
         adv_q <= 1'b0;
      end else begin
         rw_q  <= rw_d;
         ret_q <= ret_d;
         adv_q <= adv_d;
      end
   end

   assign ret_req_o = ret_q;
   assign adv_req_o = adv_q;

endmodule
`default_nettype wire

// File: rtl/dpll_ctrl_div.sv
`default_nettype none
// ============================================================================
//  Module      : dpll_ctrl_div
//  Description : Controllable divider of the bit-sync DPLL. Holds pending
//                corrections, the symbol phase counter, registered sync clocks
//                and the lock detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpll_ctrl_div
   import dpll_ctrl_div_pkg::*;
#(
   parameter int DIV_N    = DEF_DIV_N,
   parameter int FILT_K   = DEF_FILT_K,
   parameter int LOCK_SYM = DEF_LOCK_SYM
) (
   input  wire logic       clk32,
   input  wire logic       rst,
   dpll_ctrl_div_if.slave  bus
);

   localparam int CNT_W = cnt_width(DIV_N);
   localparam int LK_W  = $clog2(LOCK_SYM + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV_N - 1);
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV_N / 2);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [LK_W-1:0]  C_LOCK = LK_W'(LOCK_SYM);
   localparam logic [LK_W-1:0]  C_LK1  = LK_W'(1);

   logic             ret_req, adv_req;
   logic             boundary;
   corr_e            corr;
   logic             ret_keep, adv_keep;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold_q, hold_d;       // extra cycle at DIV_N-1 in progress
   logic             skip_q, skip_d;       // cnt reached 1 by skipping 0
   logic             pend_ret_q, pend_ret_d;
   logic             pend_adv_q, pend_adv_d;
   logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic             clk_i_q, clk_i_d;
   logic             clk_q_q, clk_q_d;
   logic             clk_sym_q, clk_sym_d;
   logic             locked_q, locked_d;

   dpll_rw_filter #(
      .FILT_K   (FILT_K)
   ) u_filt (
      .clk32    (clk32),
      .rst      (rst),
      .pd_bef_i (bus.pd_bef),
      .pd_aft_i (bus.pd_aft),
      .ret_req_o(ret_req),
      .adv_req_o(adv_req)
   );

   // Symbol boundary decision: at most one correction, never during a hold
   always_comb begin
      boundary = (cnt_q == C_LAST) && !hold_q;
      corr     = CORR_NONE;
      if (boundary && pend_ret_q)
         corr = CORR_RET;
      else if (boundary && pend_adv_q)
         corr = CORR_ADV;
   end

   // Phase counter, pending requests and lock counter next state
   always_comb begin
      // counter: hold repeats DIV_N-1, advance jumps straight to 1
      cnt_d  = cnt_q + C_ONE;
      if (hold_q)
         cnt_d = '0;
      else if (boundary)
         case (corr)
            CORR_RET: cnt_d = cnt_q;
            CORR_ADV: cnt_d = C_ONE;
            default:  cnt_d = '0;
         endcase
      hold_d = (corr == CORR_RET);
      skip_d = (corr == CORR_ADV);

      // pending: applied request clears; opposite requests annihilate
      ret_keep   = pend_ret_q && (corr != CORR_RET);
      adv_keep   = pend_adv_q && (corr != CORR_ADV);
      pend_ret_d = ret_keep;
      pend_adv_d = adv_keep;
      if (ret_req) begin
         if (adv_keep) pend_adv_d = 1'b0;
         else          pend_ret_d = 1'b1;
      end else if (adv_req) begin
         if (ret_keep) pend_ret_d = 1'b0;
         else          pend_adv_d = 1'b1;
      end

      // lock: count clean boundaries, restart on any applied correction
      lock_cnt_d = lock_cnt_q;
      if (boundary) begin
         if (corr != CORR_NONE)
            lock_cnt_d = '0;
         else if (lock_cnt_q != C_LOCK)
            lock_cnt_d = lock_cnt_q + C_LK1;
      end

      // outputs follow cnt with one cycle of latency
      clk_i_d   = (cnt_q < C_HALF);
      clk_q_d   = !(cnt_q < C_HALF);
      clk_sym_d = ((cnt_q == '0) && !hold_q) || ((cnt_q == C_ONE) && skip_q);
      locked_d  = (lock_cnt_d == C_LOCK);
   end

   // Divider state and registered outputs
   always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         hold_q     <= 1'b0;
         skip_q     <= 1'b0;
         pend_ret_q <= 1'b0;
         pend_adv_q <= 1'b0;
         lock_cnt_q <= '0;
         clk_i_q    <= 1'b0;
         clk_q_q    <= 1'b0;
         clk_sym_q  <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         skip_q     <= skip_d;
         pend_ret_q <= pend_ret_d;
         pend_adv_q <= pend_adv_d;
         lock_cnt_q <= lock_cnt_d;
         clk_i_q    <= clk_i_d;
         clk_q_q    <= clk_q_d;
         clk_sym_q  <= clk_sym_d;
         locked_q   <= locked_d;
      end
   end

   assign bus.clk_i   = clk_i_q;
   assign bus.clk_q   = clk_q_q;
   assign bus.clk_sym = clk_sym_q;
   assign bus.locked  = locked_q;

endmodule
`default_nettype wire
